me_control_param: RTL and testbench
===================================

# me_control_param

Parametrised control unit for the motion-estimation processor. It sequences the search-window and template-block address generators and the PE-array enables, and scans the SAD stream from the PE array to track the minimum SAD and its motion vector. It adds three behaviours: runtime tie-break mode, threshold early termination and abort. It sits between the host req/ack handshake and the address/PE-array datapath.

## Interface
- TB_LEN, 8, template-block side in pixels (≥2)
- SW_LEN, 32, search-window side in pixels (>TB_LEN)
- SAD_W, 16, SAD width
- PIPE_DLY, SW_LEN-TB_LEN+8, cycles from RUN entry to the first SAD sample
- VEC_W, $clog2(SW_LEN-TB_LEN+1), width of each motion-vector component
- clk  in  1  clock; the only clock
- rst  in  1  reset, synchronous, active-high
- req  in  1  start request (level)
- abort  in  1  stop the current search; sampled only in RUN
- tie_mode  in  1  0: keep the first minimum; 1: on an equal SAD, prefer the candidate closer to the centre
- thresh  in  SAD_W  early-termination threshold; 0 disables it
- sad  in  SAD_W  SAD of the current candidate from the PE array
- clr  out  1  PE-array/accumulator clear
- en_addr_sw  out  1  search-window address enable
- en_addr_tb  out  1  template-block address enable
- en_pearray_sw  out  1  PE-array search-window load enable
- en_pearray_tb  out  1  PE-array template load enable
- min_sad  out  SAD_W  best SAD so far
- min_mvec  out  2*VEC_W  {dy, dx} of the best SAD
- term  out  2  termination cause: 0 = full scan, 1 = threshold, 2 = abort
- ack  out  1  result valid; held until req falls

## Operation
- Main FSM states: INIT → WAIT_REQ → RUN → DRAIN → ACK → WAIT_REQ.
  - INIT lasts one cycle after rst.
  - WAIT_REQ: clr=1; min_sad = all-ones, min_mvec = 0, term = 0. req=1 → RUN.
  - RUN: drives the enables and the scan. The scan ends on the last sample, on a threshold hit, or on abort. Last sample or threshold hit → DRAIN. Abort → ACK directly.
  - DRAIN: 2 cycles, then ACK.
  - ACK: ack=1; outputs frozen. req=0 → WAIT_REQ.
- Enables, relative to T0 (first RUN cycle):
  - en_addr_sw is high for T0 .. T0+SW_LEN²-1.
  - en_addr_tb is high for T0 .. T0+TB_LEN²-1.
  - en_pearray_tb is en_addr_tb delayed 1 cycle.
  - en_pearray_sw is high for T0+1 .. T0+SW_LEN²+SW_LEN-TB_LEN.
  - All enables are forced low from the cycle after scan end or abort.
- Scan:
  - Sample k = 0 .. SW_LEN²-1 occurs at T0+PIPE_DLY+k.
  - Raw coordinates: y = k mod SW_LEN, x = k div SW_LEN.
  - A sample is valid iff x ≥ TB_LEN-1 and y ≥ TB_LEN-1.
  - Displacement: dx = x-(TB_LEN-1), dy = y-(TB_LEN-1), each in the range 0 .. SW_LEN-TB_LEN.
- Update rule, on a valid sample:
  - sad < min_sad → update min_sad and min_mvec.
  - sad == min_sad with tie_mode=1 → update if |dx-C|+|dy-C| is strictly less than the stored candidate's distance, where C = (SW_LEN-TB_LEN)/2 (integer division). The distance of the stored candidate is registered alongside it.
- Threshold: thresh≠0 and a valid sample with sad ≤ thresh → the update is applied, term=1, and the scan ends.
- Priority and boundary cases:
  - abort beats a threshold hit in the same cycle.
  - A threshold hit on the final sample gives term=1.
  - Abort before any valid sample leaves min_sad = all-ones and min_mvec = 0.
  - req deasserting during RUN or DRAIN is ignored.
  - abort outside RUN is ignored.
  - rst at any time returns every register to its reset value on the next edge.
- Arithmetic: comparisons are unsigned over SAD_W bits. The distance uses VEC_W+1 bits.

## Timing
- Reset values:
  - clr=0, all enables 0, ack=0, term=0.
  - min_sad = all-ones, min_mvec = 0.
  - The FSM is in INIT, so clr rises 1 cycle after rst is released.
- Results: min_sad and min_mvec update on the edge after the sample cycle.
- Full scan: last sample at Tl = T0+PIPE_DLY+SW_LEN²-1; ack rises at Tl+3.
- Threshold hit: sample at Ts; enables low at Ts+1; ack rises at Ts+3.
- Abort: sampled at Ta; enables low and ack high at Ta+1.
- Handshake timing:
  - ack falls 1 cycle after req=0 is sampled in ACK.
  - The next run can start 1 cycle after that, once in WAIT_REQ (clr high for ≥1 cycle).

## Structure
- me_pkg holds:
  - the state encodings (main FSM),
  - the term codes TERM_FULL=0, TERM_THRESH=1, TERM_ABORT=2,
  - a function that derives VEC_W.
- One sub-module, me_scan_counter, generates the scan.
  - Parameters: SW_LEN, TB_LEN.
  - Behaviour: start/stop input; outputs sample strobe, valid, last, dx, dy.
- The top level contains the main FSM, the enable counters and the min/tie tracker.

## Test plan
All scenarios use defaults (SW_LEN=32, TB_LEN=8, PIPE_DLY=32).
- Full scan: thresh=0, tie_mode=0, sad=100 everywhere except 50 at (dx=12, dy=5) → min_sad=50, min_mvec={5,12}, term=0, ack at T0+1058.
- Tie-break: sad=40 at (0,0) and at (12,12), 200 elsewhere. tie_mode=0 → mvec {0,0}; tie_mode=1 → mvec {12,12}.
- Threshold: thresh=10, sad=5 at (dx=4, dy=3), 300 elsewhere → min_sad=5, min_mvec={3,4}, term=1, enables low at Ts+1, ack at Ts+3.
- Abort: abort at T0+5 → ack at T0+6, term=2, min_sad=16'hFFFF, min_mvec=0. Then req=0 → WAIT_REQ and clr=1.
- Reset mid-run: rst at T0+400 → next cycle all outputs at reset values. A subsequent req gives a correct full-scan result.
- Handshake: req held high through ACK → ack stays high and no new run starts. req low → ack low next cycle.

Source files
------------

// File: rtl/me_pkg.sv
// Shared types and constants for the motion-estimation control unit.
package me_pkg;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_WAIT_REQ = 3'd1,
        ST_RUN      = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_ACK      = 3'd4
    } state_e;

    localparam logic [1:0] TERM_FULL   = 2'd0;
    localparam logic [1:0] TERM_THRESH = 2'd1;
    localparam logic [1:0] TERM_ABORT  = 2'd2;

    // Width of one motion-vector component for a given window/template size.
    function automatic int unsigned vec_w(input int unsigned sw_len, input int unsigned tb_len);
        return $clog2(sw_len - tb_len + 1);
    endfunction

endpackage

// File: rtl/me_control_param_if.sv
// Host handshake, PE-array SAD input and datapath enable/result bundle.
interface me_control_param_if #(
    parameter int unsigned SAD_W = 16,
    parameter int unsigned VEC_W = 5
);
    logic               req;
    logic               abort;
    logic               tie_mode;
    logic [SAD_W-1:0]   thresh;
    logic [SAD_W-1:0]   sad;
    logic               clr;
    logic               en_addr_sw;
    logic               en_addr_tb;
    logic               en_pearray_sw;
    logic               en_pearray_tb;
    logic [SAD_W-1:0]   min_sad;
    logic [2*VEC_W-1:0] min_mvec;
    logic [1:0]         term;
    logic               ack;

    modport master (
        output req, abort, tie_mode, thresh, sad,
        input  clr, en_addr_sw, en_addr_tb, en_pearray_sw, en_pearray_tb,
               min_sad, min_mvec, term, ack
    );

    modport slave (
        input  req, abort, tie_mode, thresh, sad,
        output clr, en_addr_sw, en_addr_tb, en_pearray_sw, en_pearray_tb,
               min_sad, min_mvec, term, ack
    );
endinterface

// File: rtl/me_scan_counter.sv
// Walks the SAD sample stream column-major (y fastest) and flags in-window candidates.
module me_scan_counter
    import me_pkg::*;
#(
    parameter int unsigned SW_LEN = 32,
    parameter int unsigned TB_LEN = 8,
    parameter int unsigned VEC_W  = vec_w(SW_LEN, TB_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    output logic             strobe_c,
    output logic             valid_c,
    output logic             last_c,
    output logic [VEC_W-1:0] dx_c,
    output logic [VEC_W-1:0] dy_c
);
    localparam int unsigned XY_W = $clog2(SW_LEN);
    localparam logic [XY_W-1:0] XY_MAX = XY_W'(SW_LEN - 1);
    localparam logic [XY_W-1:0] OFS    = XY_W'(TB_LEN - 1);

    logic            active_q;
    logic [XY_W-1:0] x_q;
    logic [XY_W-1:0] y_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else if (stop) begin
            active_q <= 1'b0;
        end else if (start) begin
            active_q <= 1'b1;
            x_q      <= '0;
            y_q      <= '0;
        end else if (active_q) begin
            if (y_q == XY_MAX) begin
                y_q <= '0;
                if (x_q == XY_MAX) active_q <= 1'b0;
                else               x_q      <= x_q + XY_W'(1);
            end else begin
                y_q <= y_q + XY_W'(1);
            end
        end
    end

    always_comb begin
        strobe_c = active_q;
        last_c   = active_q && (x_q == XY_MAX) && (y_q == XY_MAX);
        valid_c  = active_q && (x_q >= OFS) && (y_q >= OFS);
        dx_c     = VEC_W'(x_q - OFS);
        dy_c     = VEC_W'(y_q - OFS);
    end

endmodule

// File: rtl/me_control_param.sv
// Motion-estimation control: run sequencing, datapath enables and minimum-SAD tracking.
module me_control_param
    import me_pkg::*;
#(
    parameter int unsigned TB_LEN   = 8,
    parameter int unsigned SW_LEN   = 32,
    parameter int unsigned SAD_W    = 16,
    parameter int unsigned PIPE_DLY = SW_LEN - TB_LEN + 8,
    parameter int unsigned VEC_W    = vec_w(SW_LEN, TB_LEN)
) (
    input logic               clk,
    input logic               rst,
    me_control_param_if.slave bus
);
    localparam int unsigned SW_SQ   = SW_LEN * SW_LEN;
    localparam int unsigned TB_SQ   = TB_LEN * TB_LEN;
    localparam int unsigned PSW_END = SW_SQ + SW_LEN - TB_LEN;
    localparam int unsigned CNT_W   = $clog2(PIPE_DLY + SW_SQ + 1);
    localparam int unsigned DIST_W  = VEC_W + 1;
    localparam logic [VEC_W-1:0] CTR_V = VEC_W'((SW_LEN - TB_LEN) / 2);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               drain_q, drain_d;
    logic [SAD_W-1:0]   min_sad_q, min_sad_d;
    logic [2*VEC_W-1:0] min_mvec_q, min_mvec_d;
    logic [DIST_W-1:0]  min_dist_q, min_dist_d;
    logic [1:0]         term_q, term_d;
    logic               clr_q, clr_d;
    logic               en_sw_q, en_sw_d, en_tb_q, en_tb_d;
    logic               en_psw_q, en_psw_d, en_ptb_q, en_ptb_d;
    logic               ack_q, ack_d;

    logic               scan_start_c, scan_stop_c;
    logic               smp_c, valid_c, last_c;
    logic [VEC_W-1:0]   dx_c, dy_c;
    logic [DIST_W-1:0]  adx_c, ady_c, dist_c;
    logic               better_c, thr_hit_c, run_c;

    me_scan_counter #(
        .SW_LEN (SW_LEN),
        .TB_LEN (TB_LEN),
        .VEC_W  (VEC_W)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .start    (scan_start_c),
        .stop     (scan_stop_c),
        .strobe_c (smp_c),
        .valid_c  (valid_c),
        .last_c   (last_c),
        .dx_c     (dx_c),
        .dy_c     (dy_c)
    );

    // Manhattan distance of the current candidate from the window centre.
    always_comb begin
        adx_c  = (dx_c >= CTR_V) ? DIST_W'(dx_c - CTR_V) : DIST_W'(CTR_V - dx_c);
        ady_c  = (dy_c >= CTR_V) ? DIST_W'(dy_c - CTR_V) : DIST_W'(CTR_V - dy_c);
        dist_c = adx_c + ady_c;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        drain_d    = 1'b0;
        min_sad_d  = min_sad_q;
        min_mvec_d = min_mvec_q;
        min_dist_d = min_dist_q;
        term_d     = term_q;
        better_c   = 1'b0;
        thr_hit_c  = 1'b0;

        case (state_q)
            ST_INIT:     state_d = ST_WAIT_REQ;
            ST_WAIT_REQ: if (bus.req) state_d = ST_RUN;
            ST_RUN: begin
                better_c  = smp_c && valid_c &&
                            ((bus.sad < min_sad_q) ||
                             (bus.tie_mode && (bus.sad == min_sad_q) && (dist_c < min_dist_q)));
                thr_hit_c = smp_c && valid_c && (bus.thresh != '0) && (bus.sad <= bus.thresh);
                // Abort wins over everything, including a same-cycle sample.
                if (bus.abort) begin
                    state_d = ST_ACK;
                    term_d  = TERM_ABORT;
                end else begin
                    if (better_c || thr_hit_c) begin
                        min_sad_d  = bus.sad;
                        min_mvec_d = {dy_c, dx_c};
                        min_dist_d = dist_c;
                    end
                    if (thr_hit_c) begin
                        state_d = ST_DRAIN;
                        term_d  = TERM_THRESH;
                    end else if (smp_c && last_c) begin
                        state_d = ST_DRAIN;
                        term_d  = TERM_FULL;
                    end
                end
            end
            ST_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) state_d = ST_ACK;
            end
            ST_ACK:  if (!bus.req) state_d = ST_WAIT_REQ;
            default: state_d = ST_INIT;
        endcase

        if (state_d == ST_WAIT_REQ) begin
            min_sad_d  = '1;
            min_mvec_d = '0;
            min_dist_d = '1;
            term_d     = TERM_FULL;
        end

        if ((state_q == ST_RUN) && (state_d == ST_RUN)) cnt_d = cnt_q + CNT_W'(1);

        // Enables are registered from next-state so they line up with the first RUN cycle.
        run_c    = (state_d == ST_RUN);
        clr_d    = (state_d == ST_WAIT_REQ);
        en_sw_d  = run_c && (cnt_d < CNT_W'(SW_SQ));
        en_tb_d  = run_c && (cnt_d < CNT_W'(TB_SQ));
        en_ptb_d = run_c && (cnt_d >= CNT_W'(1)) && (cnt_d <= CNT_W'(TB_SQ));
        en_psw_d = run_c && (cnt_d >= CNT_W'(1)) && (cnt_d <= CNT_W'(PSW_END));
        ack_d    = (state_d == ST_ACK);
    end

    assign scan_start_c = (state_q == ST_RUN) && (state_d == ST_RUN) &&
                          (cnt_q == CNT_W'(PIPE_DLY - 1));
    assign scan_stop_c  = (state_q == ST_RUN) && (state_d != ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            drain_q    <= 1'b0;
            min_sad_q  <= '1;
            min_mvec_q <= '0;
            min_dist_q <= '1;
            term_q     <= TERM_FULL;
            clr_q      <= 1'b0;
            en_sw_q    <= 1'b0;
            en_tb_q    <= 1'b0;
            en_psw_q   <= 1'b0;
            en_ptb_q   <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            min_sad_q  <= min_sad_d;
            min_mvec_q <= min_mvec_d;
            min_dist_q <= min_dist_d;
            term_q     <= term_d;
            clr_q      <= clr_d;
            en_sw_q    <= en_sw_d;
            en_tb_q    <= en_tb_d;
            en_psw_q   <= en_psw_d;
            en_ptb_q   <= en_ptb_d;
            ack_q      <= ack_d;
        end
    end

    assign bus.clr           = clr_q;
    assign bus.en_addr_sw    = en_sw_q;
    assign bus.en_addr_tb    = en_tb_q;
    assign bus.en_pearray_sw = en_psw_q;
    assign bus.en_pearray_tb = en_ptb_q;
    assign bus.min_sad       = min_sad_q;
    assign bus.min_mvec      = min_mvec_q;
    assign bus.term          = term_q;
    assign bus.ack           = ack_q;

endmodule

// File: tb/tb_me_control_param.sv
// Directed table-driven bench for me_control_param at default geometry.
module tb_me_control_param;
    import me_pkg::*;

    localparam int unsigned TB_LEN   = 8;
    localparam int unsigned SW_LEN   = 32;
    localparam int unsigned SAD_W    = 16;
    localparam int unsigned PIPE_DLY = 32;
    localparam int unsigned VEC_W    = 5;
    localparam int          RUN_MAX  = 1200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    me_control_param_if #(.SAD_W(SAD_W), .VEC_W(VEC_W)) bus ();

    me_control_param #(
        .TB_LEN   (TB_LEN),
        .SW_LEN   (SW_LEN),
        .SAD_W    (SAD_W),
        .PIPE_DLY (PIPE_DLY),
        .VEC_W    (VEC_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          mode;
        logic        tm;
        logic [15:0] th;
        int          abort_at;
        logic [15:0] exp_sad;
        int          exp_dy;
        int          exp_dx;
        logic [1:0]  exp_term;
        int          exp_ack;
    } vec_t;

    vec_t vecs [8];
    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else             n_pass++;
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // SAD presented for sample k; out-of-window samples get 1 so a broken valid filter shows up.
    function automatic logic [15:0] pat(input int mode, input int k);
        int x, y, dx, dy;
        if (k < 0 || k >= 1024) return 16'd0;
        x = k / 32;
        y = k % 32;
        if (x < 7 || y < 7) return 16'd1;
        dx = x - 7;
        dy = y - 7;
        case (mode)
            0:       return (dx == 12 && dy == 5) ? 16'd50 : 16'd100;
            1:       return ((dx == 0 && dy == 0) || (dx == 12 && dy == 12)) ? 16'd40 : 16'd200;
            2:       return (dx == 4 && dy == 3) ? 16'd5 : 16'd300;
            default: return (dx == 24 && dy == 24) ? 16'd7 : 16'd500;
        endcase
    endfunction

    task automatic rst_checks(input string tag);
        chk({tag, " clr"}, 32'(bus.clr), 0);
        chk({tag, " ack"}, 32'(bus.ack), 0);
        chk({tag, " enables"}, 32'({bus.en_addr_sw, bus.en_addr_tb, bus.en_pearray_sw, bus.en_pearray_tb}), 0);
        chk({tag, " term"}, 32'(bus.term), 0);
        chk({tag, " min_sad"}, 32'(bus.min_sad), 32'hFFFF);
        chk({tag, " min_mvec"}, 32'(bus.min_mvec), 0);
    endtask

    // Starts from WAIT_REQ just after an edge; runs one search, checks results and handshake.
    task automatic do_run(input int r, input vec_t v);
        int j, ack_j, stop_j, clr_run;
        int sw_first, sw_last, tb_last, ptb_first, ptb_last, psw_first, psw_last;
        string tag;
        tag = $sformatf("row%0d", r);
        ack_j = -1; clr_run = 0;
        sw_first = -1; sw_last = -1; tb_last = -1;
        ptb_first = -1; ptb_last = -1; psw_first = -1; psw_last = -1;
        bus.req = 1'b1; bus.tie_mode = v.tm; bus.thresh = v.th; bus.abort = 1'b0; bus.sad = '0;
        @(posedge clk); #1;
        j = 0;
        while (j < RUN_MAX) begin
            bus.sad   = pat(v.mode, j - int'(PIPE_DLY));
            bus.abort = (j == v.abort_at);
            if (v.abort_at < 0) bus.req = !((j >= 10 && j < 20) || j == v.exp_ack - 1);
            if (bus.clr) clr_run++;
            if (bus.en_addr_sw) begin if (sw_first < 0) sw_first = j; sw_last = j; end
            if (bus.en_addr_tb) tb_last = j;
            if (bus.en_pearray_tb) begin if (ptb_first < 0) ptb_first = j; ptb_last = j; end
            if (bus.en_pearray_sw) begin if (psw_first < 0) psw_first = j; psw_last = j; end
            if (bus.ack) begin ack_j = j; break; end
            @(posedge clk); #1;
            j++;
        end
        stop_j = (v.abort_at >= 0) ? v.abort_at : v.exp_ack - 3;
        chk({tag, " ack_cycle"}, 32'(ack_j), 32'(v.exp_ack));
        chk({tag, " min_sad"}, 32'(bus.min_sad), 32'(v.exp_sad));
        chk({tag, " min_mvec"}, 32'(bus.min_mvec), 32'((v.exp_dy << 5) | v.exp_dx));
        chk({tag, " term"}, 32'(bus.term), 32'(v.exp_term));
        chk({tag, " sw_first"}, 32'(sw_first), 0);
        chk({tag, " sw_last"}, 32'(sw_last), 32'(imin(1023, stop_j)));
        chk({tag, " tb_last"}, 32'(tb_last), 32'(imin(63, stop_j)));
        chk({tag, " ptb_first"}, 32'(ptb_first), 1);
        chk({tag, " ptb_last"}, 32'(ptb_last), 32'(imin(64, stop_j)));
        chk({tag, " psw_first"}, 32'(psw_first), 1);
        chk({tag, " psw_last"}, 32'(psw_last), 32'(imin(1048, stop_j)));
        chk({tag, " clr_in_run"}, 32'(clr_run), 0);
        // Hold req in ACK, poke abort: results must stay frozen and no new run may start.
        bus.req = 1'b1; bus.abort = 1'b1; bus.sad = 16'd0;
        repeat (3) begin @(posedge clk); #1; end
        chk({tag, " ack_held"}, 32'(bus.ack), 1);
        chk({tag, " no_restart"}, 32'({bus.en_addr_sw, bus.clr}), 0);
        chk({tag, " term_frozen"}, 32'(bus.term), 32'(v.exp_term));
        chk({tag, " sad_frozen"}, 32'(bus.min_sad), 32'(v.exp_sad));
        bus.abort = 1'b0; bus.req = 1'b0;
        @(posedge clk); #1;
        chk({tag, " ack_fall"}, 32'(bus.ack), 0);
        chk({tag, " clr_idle"}, 32'(bus.clr), 1);
        chk({tag, " sad_cleared"}, 32'(bus.min_sad), 32'hFFFF);
    endtask

    initial begin
        rst = 1'b1;
        bus.req = 1'b0; bus.abort = 1'b0; bus.tie_mode = 1'b0; bus.thresh = '0; bus.sad = '0;

        vecs[0] = '{0, 1'b0, 16'd0,   -1,  16'd50,    5,  12, 2'd0, 1058};
        vecs[1] = '{1, 1'b0, 16'd0,   -1,  16'd40,    0,  0,  2'd0, 1058};
        vecs[2] = '{1, 1'b1, 16'd0,   -1,  16'd40,    12, 12, 2'd0, 1058};
        vecs[3] = '{2, 1'b0, 16'd10,  -1,  16'd5,     3,  4,  2'd1, 397};
        vecs[4] = '{0, 1'b0, 16'd0,   5,   16'hFFFF,  0,  0,  2'd2, 6};
        vecs[5] = '{0, 1'b0, 16'd100, -1,  16'd100,   0,  0,  2'd1, 266};
        vecs[6] = '{3, 1'b0, 16'd8,   -1,  16'd7,     24, 24, 2'd1, 1058};
        vecs[7] = '{0, 1'b0, 16'd0,   332, 16'd100,   0,  0,  2'd2, 333};

        repeat (3) @(posedge clk);
        #1;
        rst_checks("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("clr_after_reset", 32'(bus.clr), 1);

        bus.abort = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("idle_abort ack", 32'(bus.ack), 0);
        chk("idle_abort clr", 32'(bus.clr), 1);
        bus.abort = 1'b0;

        for (int i = 0; i < 8; i++) do_run(i, vecs[i]);

        // Reset in the middle of a full scan, then a clean rerun.
        bus.req = 1'b1; bus.tie_mode = 1'b0; bus.thresh = '0;
        @(posedge clk); #1;
        for (int j = 0; j < 400; j++) begin
            bus.sad = pat(0, j - int'(PIPE_DLY));
            @(posedge clk); #1;
        end
        chk("midrun min_sad", 32'(bus.min_sad), 100);
        chk("midrun en_addr_sw", 32'(bus.en_addr_sw), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst_checks("midrun_reset");
        rst = 1'b0; bus.req = 1'b0;
        @(posedge clk); #1;
        chk("clr_after_midrun_reset", 32'(bus.clr), 1);
        do_run(8, vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
